execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Pipeline EX stage of the RV32 core; sits between decode and the memory stage.
- Computes the ALU result / load-store address, resolves branches and forwards the store data.
- Registers everything into the EX/MEM boundary.
- Single-cycle ALU ops; DIV/DIVU/REM/REMU run on an iterative radix-2 divider and stall upstream via busy.

Parameters:
- XLEN, 32, datapath width.
- DIV_EN, 1, when 0 division opcodes produce 0 in one cycle and busy never asserts.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  sync squash of the instruction in EX; aborts divider
- pc  in  32  PC of the instruction in EX
- rs1_data  in  32  operand A
- rs2_data  in  32  register B / store data
- imm  in  32  sign-extended immediate
- ALUSrc  in  1  1: B=imm, 0: B=rs2_data
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 DIV, 11 DIVU, 12 REM, 13 REMU, 14 PASSB, 15 result 0
- Branch  in  1  conditional branch
- branch_type  in  3  funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU
- in_MemRead, in_MemWrite, in_MemToReg, in_RegWrite, in_RegDataSrc  in  1 each  decode control, passed through
- in_RegDest  in  5  destination register
- busy  out  1  combinational; upstream must hold all inputs stable while high
- out_AluResult  out  32  registered result / memory address
- out_StoreData  out  32  registered rs2_data
- out_BranchTarget  out  32  registered pc+imm
- out_PCSrc  out  1  registered branch taken
- out_MemRead, out_MemWrite, out_MemToReg, out_RegWrite, out_RegDataSrc  out  1 each  registered
- out_RegDest  out  5  registered

Behaviour:
- Reset: all registered outputs 0, FSM IDLE, divider regs 0. Reset mid-division discards it.
- Non-div op: output regs capture result and controls at the next edge (latency 1).
- Shifts use B[4:0]. SLT is signed, SLTU unsigned; both give 0/1.
- PCSrc = Branch & condition(rs1_data, rs2_data) — always rs2, never imm. BranchTarget = pc+imm, wrap mod 2^32.
- Divider FSM: IDLE, RUN, DONE.
  - busy = div_op & (state != DONE).
  - IDLE with div_op: latch |A|, |B|, signs and op; counter=31; go to RUN.
  - RUN: one restoring step per edge; at counter 0 go to DONE.
  - DONE: busy=0; output regs capture the corrected result with current controls; go to IDLE.
  - A div instruction yields 33 bubbles, then its result on the 34th edge after first sampling.
- While busy, output regs load a bubble: all control outs 0, PCSrc 0, data 0.
- Signed correction: quotient negated if the signs differ; remainder takes the dividend's sign.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend (REM and REMU).
- Overflow (0x80000000 / -1, signed): quotient 0x80000000, remainder 0.
- Special cases keep the full 34-edge latency.
- flush has priority over all: output regs load a bubble, FSM goes to IDLE, busy drops the same cycle (combinationally gated by flush).
- A div op still present after a flush restarts from IDLE.
- Back-to-back div ops: DONE goes to IDLE, then the next div starts on the following edge.

Test Plan:
- ADD, rs1=0x7FFFFFFF, rs2=1, ALUSrc=0, RegWrite=1, RegDest=5 -> next edge AluResult=0x80000000, RegWrite=1, RegDest=5.
- SRA, rs1=0x80000000, imm=4, ALUSrc=1 -> 0xF8000000. SLT(-1,1)=1; SLTU(-1,1)=0.
- Branch=1, branch_type=100, rs1=-3, rs2=2, pc=0x100, imm=-8 -> PCSrc=1, BranchTarget=0xF8. With branch_type=110 -> PCSrc=0.
- DIV -7/2 -> 33 bubble edges with busy=1, then AluResult=0xFFFFFFFD. REM gives 0xFFFFFFFF. DIVU x/0 gives 0xFFFFFFFF. DIV 0x80000000/-1 gives 0x80000000.
- Flush at RUN edge 10 -> busy drops, next output is a bubble, FSM IDLE. Subsequent ADD completes in 1 cycle.
- Assert rst mid-RUN -> all outputs 0 immediately. After release, a new DIVU 100/7 gives 14 after 34 edges.

Source files
------------

// File: rtl/execute_stage.sv
// RV32 execute stage: ALU, branch resolution and an iterative restoring divider,
// all results registered into the EX/MEM boundary.
module execute_stage #(
    parameter int unsigned XLEN   = 32,
    parameter bit          DIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            ALUSrc,
    input  logic [3:0]      alu_op,
    input  logic            Branch,
    input  logic [2:0]      branch_type,
    input  logic            in_MemRead,
    input  logic            in_MemWrite,
    input  logic            in_MemToReg,
    input  logic            in_RegWrite,
    input  logic            in_RegDataSrc,
    input  logic [4:0]      in_RegDest,
    output logic            busy,
    output logic [XLEN-1:0] out_AluResult,
    output logic [XLEN-1:0] out_StoreData,
    output logic [XLEN-1:0] out_BranchTarget,
    output logic            out_PCSrc,
    output logic            out_MemRead,
    output logic            out_MemWrite,
    output logic            out_MemToReg,
    output logic            out_RegWrite,
    output logic            out_RegDataSrc,
    output logic [4:0]      out_RegDest
);
    localparam int unsigned ShW = $clog2(XLEN);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpSll  = 4'd5;
    localparam logic [3:0] OpSrl  = 4'd6;
    localparam logic [3:0] OpSra  = 4'd7;
    localparam logic [3:0] OpSlt  = 4'd8;
    localparam logic [3:0] OpSltu = 4'd9;
    localparam logic [3:0] OpDiv  = 4'd10;
    localparam logic [3:0] OpRemu = 4'd13;
    localparam logic [3:0] OpPass = 4'd14;

    typedef enum logic [1:0] {StIdle, StRun, StDone} div_state_e;

    div_state_e      state_q;
    logic [ShW-1:0]  cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, divisor_q, dividend_q;
    logic            q_neg_q, r_neg_q, b_zero_q, is_rem_q;

    logic [XLEN-1:0] op_b, alu_res, abs_a, abs_b, q_res, r_res, div_res;
    logic [ShW-1:0]  shamt;
    logic [XLEN:0]   rem_sh, diff;
    logic            div_op, div_signed, branch_cond;

    always_comb begin
        op_b    = ALUSrc ? imm : rs2_data;
        shamt   = op_b[ShW-1:0];
        div_op  = DIV_EN && (alu_op >= OpDiv) && (alu_op <= OpRemu);
        alu_res = '0;
        case (alu_op)
            OpAdd:   alu_res = rs1_data + op_b;
            OpSub:   alu_res = rs1_data - op_b;
            OpAnd:   alu_res = rs1_data & op_b;
            OpOr:    alu_res = rs1_data | op_b;
            OpXor:   alu_res = rs1_data ^ op_b;
            OpSll:   alu_res = rs1_data << shamt;
            OpSrl:   alu_res = rs1_data >> shamt;
            OpSra:   alu_res = $unsigned($signed(rs1_data) >>> shamt);
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(op_b)};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, rs1_data < op_b};
            OpPass:  alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Branch compares always use rs2_data, never the immediate.
    always_comb begin
        branch_cond = 1'b0;
        case (branch_type)
            3'b000:  branch_cond = rs1_data == rs2_data;
            3'b001:  branch_cond = rs1_data != rs2_data;
            3'b100:  branch_cond = $signed(rs1_data) < $signed(rs2_data);
            3'b101:  branch_cond = $signed(rs1_data) >= $signed(rs2_data);
            3'b110:  branch_cond = rs1_data < rs2_data;
            3'b111:  branch_cond = rs1_data >= rs2_data;
            default: branch_cond = 1'b0;
        endcase
    end

    // DIV/REM are even codes (signed), DIVU/REMU odd; bit 2 selects remainder.
    always_comb begin
        div_signed = ~alu_op[0];
        abs_a      = (div_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
        abs_b      = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;
        rem_sh     = {rem_q, quo_q[XLEN-1]};
        diff       = rem_sh - {1'b0, divisor_q};
        q_res      = b_zero_q ? '1 : (q_neg_q ? -quo_q : quo_q);
        r_res      = b_zero_q ? dividend_q : (r_neg_q ? -rem_q : rem_q);
        div_res    = is_rem_q ? r_res : q_res;
        busy       = div_op && (state_q != StDone) && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            b_zero_q   <= 1'b0;
            is_rem_q   <= 1'b0;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: if (div_op) begin
                    quo_q      <= abs_a;
                    rem_q      <= '0;
                    divisor_q  <= abs_b;
                    dividend_q <= rs1_data;
                    q_neg_q    <= div_signed && (rs1_data[XLEN-1] ^ op_b[XLEN-1]);
                    r_neg_q    <= div_signed && rs1_data[XLEN-1];
                    b_zero_q   <= op_b == '0;
                    is_rem_q   <= alu_op[2];
                    cnt_q      <= ShW'(XLEN - 1);
                    state_q    <= StRun;
                end
                StRun: begin
                    if (!diff[XLEN]) begin
                        rem_q <= diff[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == '0) state_q <= StDone;
                    else cnt_q <= cnt_q - 1'b1;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // A div op that is not busy is in DONE, so div_res is final here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || busy) begin
            if (rst) begin
                out_AluResult <= '0;
            end
            out_AluResult    <= '0;
            out_StoreData    <= '0;
            out_BranchTarget <= '0;
            out_PCSrc        <= 1'b0;
            out_MemRead      <= 1'b0;
            out_MemWrite     <= 1'b0;
            out_MemToReg     <= 1'b0;
            out_RegWrite     <= 1'b0;
            out_RegDataSrc   <= 1'b0;
            out_RegDest      <= '0;
        end else begin
            out_AluResult    <= div_op ? div_res : alu_res;
            out_StoreData    <= rs2_data;
            out_BranchTarget <= pc + imm;
            out_PCSrc        <= Branch && branch_cond;
            out_MemRead      <= in_MemRead;
            out_MemWrite     <= in_MemWrite;
            out_MemToReg     <= in_MemToReg;
            out_RegWrite     <= in_RegWrite;
            out_RegDataSrc   <= in_RegDataSrc;
            out_RegDest      <= in_RegDest;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic        ALUSrc, Branch;
    logic [3:0]  alu_op;
    logic [2:0]  branch_type;
    logic        in_MemRead, in_MemWrite, in_MemToReg, in_RegWrite, in_RegDataSrc;
    logic [4:0]  in_RegDest;
    logic        busy;
    logic [31:0] out_AluResult, out_StoreData, out_BranchTarget;
    logic        out_PCSrc, out_MemRead, out_MemWrite, out_MemToReg, out_RegWrite, out_RegDataSrc;
    logic [4:0]  out_RegDest;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32), .DIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .pc(pc), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm(imm), .ALUSrc(ALUSrc), .alu_op(alu_op), .Branch(Branch),
        .branch_type(branch_type), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
        .in_MemToReg(in_MemToReg), .in_RegWrite(in_RegWrite), .in_RegDataSrc(in_RegDataSrc),
        .in_RegDest(in_RegDest), .busy(busy), .out_AluResult(out_AluResult),
        .out_StoreData(out_StoreData), .out_BranchTarget(out_BranchTarget),
        .out_PCSrc(out_PCSrc), .out_MemRead(out_MemRead), .out_MemWrite(out_MemWrite),
        .out_MemToReg(out_MemToReg), .out_RegWrite(out_RegWrite),
        .out_RegDataSrc(out_RegDataSrc), .out_RegDest(out_RegDest)
    );

    typedef logic [106:0] obs_t;
    wire obs_t obs = {out_AluResult, out_StoreData, out_BranchTarget, out_PCSrc, out_MemRead,
                      out_MemWrite, out_MemToReg, out_RegWrite, out_RegDataSrc, out_RegDest};

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a, b, imm, pc;
        logic        alusrc, branch;
        logic [2:0]  bt;
        logic [4:0]  ctrl; // {MemRead, MemWrite, MemToReg, RegWrite, RegDataSrc}
        logic [4:0]  rd;
    } stim_t;

    function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a, b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) return (op == 4'd10 || op == 4'd11) ? 32'hFFFFFFFF : a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF && op == 4'd10) return 32'h80000000;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF && op == 4'd12) return 32'd0;
        case (op)
            4'd10:   return 32'(sa / sb);
            4'd11:   return a / b;
            4'd12:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'(sa >>> b[4:0]);
            4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd14:   return b;
            4'd15:   return 32'd0;
            default: return ref_div(op, a, b);
        endcase
    endfunction

    function automatic logic ref_branch(input logic [2:0] bt, input logic [31:0] a, b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (bt)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic obs_t expect_of(input stim_t s);
        logic [31:0] bv;
        bv = s.alusrc ? s.imm : s.b;
        return {ref_alu(s.op, s.a, bv), s.b, s.pc + s.imm, s.branch && ref_branch(s.bt, s.a, s.b),
                s.ctrl, s.rd};
    endfunction

    function automatic stim_t rand_stim(input logic [3:0] op);
        stim_t s;
        s.op     = op;
        s.a      = $urandom;
        s.b      = $urandom;
        s.imm    = $urandom;
        s.pc     = $urandom;
        s.alusrc = 1'($urandom_range(0, 1));
        s.branch = 1'($urandom_range(0, 1));
        s.bt     = 3'($urandom_range(0, 7));
        s.ctrl   = 5'($urandom_range(0, 31));
        s.rd     = 5'($urandom_range(0, 31));
        return s;
    endfunction

    function automatic logic [31:0] corner(input int sel);
        case (sel)
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(1, 100));
            default: return $urandom;
        endcase
    endfunction

    task automatic apply(input stim_t s);
        alu_op = s.op; rs1_data = s.a; rs2_data = s.b; imm = s.imm; pc = s.pc;
        ALUSrc = s.alusrc; Branch = s.branch; branch_type = s.bt; in_RegDest = s.rd;
        {in_MemRead, in_MemWrite, in_MemToReg, in_RegWrite, in_RegDataSrc} = s.ctrl;
    endtask

    task automatic test_reset();
        @(negedge clk);
        apply(rand_stim(4'd0));
        #1;
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL reset_async: got %h expected 0", obs); end
        @(posedge clk); #1;
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL reset_held: got %h expected 0", obs); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_directed();
        stim_t s;
        s = '0; s.op = 4'd0; s.a = 32'h7FFFFFFF; s.b = 32'd1; s.ctrl = 5'b00010; s.rd = 5'd5;
        @(negedge clk); apply(s); @(posedge clk); #1;
        checks++;
        if (out_AluResult !== 32'h80000000 || out_RegWrite !== 1'b1 || out_RegDest !== 5'd5) begin
            failures++;
            $display("FAIL add_ovf: got %h/%b/%0d expected 80000000/1/5",
                     out_AluResult, out_RegWrite, out_RegDest);
        end
        s = '0; s.op = 4'd7; s.a = 32'h80000000; s.imm = 32'd4; s.alusrc = 1'b1;
        @(negedge clk); apply(s); @(posedge clk); #1;
        checks++;
        if (out_AluResult !== 32'hF8000000) begin
            failures++; $display("FAIL sra: got %h expected f8000000", out_AluResult);
        end
        s = '0; s.op = 4'd8; s.a = 32'hFFFFFFFF; s.b = 32'd1;
        @(negedge clk); apply(s); @(posedge clk); #1;
        checks++;
        if (out_AluResult !== 32'd1) begin
            failures++; $display("FAIL slt: got %h expected 1", out_AluResult);
        end
        s.op = 4'd9;
        @(negedge clk); apply(s); @(posedge clk); #1;
        checks++;
        if (out_AluResult !== 32'd0) begin
            failures++; $display("FAIL sltu: got %h expected 0", out_AluResult);
        end
        s = '0; s.branch = 1'b1; s.bt = 3'b100; s.a = 32'hFFFFFFFD; s.b = 32'd2;
        s.pc = 32'h100; s.imm = 32'hFFFFFFF8; s.alusrc = 1'b1;
        @(negedge clk); apply(s); @(posedge clk); #1;
        checks++;
        if (out_PCSrc !== 1'b1 || out_BranchTarget !== 32'hF8) begin
            failures++;
            $display("FAIL blt: got %b/%h expected 1/000000f8", out_PCSrc, out_BranchTarget);
        end
        s.bt = 3'b110;
        @(negedge clk); apply(s); @(posedge clk); #1;
        checks++;
        if (out_PCSrc !== 1'b0) begin
            failures++; $display("FAIL bltu: got %b expected 0", out_PCSrc);
        end
    endtask

    task automatic test_alu_random();
        logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                                4'd14, 4'd15};
        stim_t s;
        for (int i = 0; i < 60; i++) begin
            s = rand_stim(ops[$urandom_range(0, 11)]);
            if (i % 4 == 0) s.b = s.a; // exercise equality branches
            @(negedge clk); apply(s); #1;
            checks++;
            if (busy !== 1'b0) begin failures++; $display("FAIL alu_busy: got %b expected 0", busy); end
            @(posedge clk); #1;
            checks++;
            if (obs !== expect_of(s)) begin
                failures++;
                $display("FAIL alu_rand op=%0d: got %h expected %h", s.op, obs, expect_of(s));
            end
        end
    endtask

    task automatic test_div();
        stim_t list[$];
        stim_t s;
        obs_t exp;
        s = '0; s.op = 4'd10; s.a = 32'hFFFFFFF9; s.b = 32'd2; s.ctrl = 5'b00010; s.rd = 5'd3;
        list.push_back(s);
        s.op = 4'd12; list.push_back(s);
        s.op = 4'd11; s.a = 32'h1234; s.b = 32'd0; list.push_back(s);
        s.op = 4'd12; s.a = 32'hFFFFFF00; list.push_back(s);
        s.op = 4'd10; s.a = 32'h80000000; s.b = 32'hFFFFFFFF; list.push_back(s);
        s.op = 4'd12; list.push_back(s);
        for (int i = 0; i < 8; i++) begin
            s = rand_stim(4'(10 + $urandom_range(0, 3)));
            s.alusrc = 1'b0;
            s.a = corner($urandom_range(0, 6));
            s.b = corner($urandom_range(0, 6));
            s.ctrl[1] = 1'b1;
            list.push_back(s);
        end
        foreach (list[k]) begin
            s = list[k];
            exp = expect_of(s);
            @(negedge clk); apply(s);
            for (int e = 1; e <= 34; e++) begin
                #1;
                checks++;
                if (busy !== (e <= 33)) begin
                    failures++; $display("FAIL div_busy[%0d] edge %0d: got %b", k, e, busy);
                end
                @(posedge clk); #1;
                checks++;
                if (e < 34 && obs !== '0) begin
                    failures++; $display("FAIL div_bubble[%0d] edge %0d: got %h expected 0", k, e, obs);
                end else if (e == 34 && obs !== exp) begin
                    failures++;
                    $display("FAIL div_result[%0d] op=%0d a=%h b=%h: got %h expected %h",
                             k, s.op, s.a, s.b, obs, exp);
                end
                if (e < 34) @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        obs_t exp;
        s = rand_stim(4'd11);
        s.alusrc = 1'b0; s.b = corner(3); s.ctrl[1] = 1'b1;
        exp = expect_of(s);
        @(negedge clk); apply(s);
        for (int e = 1; e <= 68; e++) begin
            #1;
            checks++;
            if (busy !== (e != 34 && e != 68)) begin
                failures++; $display("FAIL b2b_busy edge %0d: got %b", e, busy);
            end
            @(posedge clk); #1;
            checks++;
            if (obs !== ((e == 34 || e == 68) ? exp : obs_t'(0))) begin
                failures++; $display("FAIL b2b_out edge %0d: got %h", e, obs);
            end
            @(negedge clk);
        end
        s = '0; apply(s);
    endtask

    task automatic test_flush();
        stim_t s, d;
        obs_t exp;
        int lat;
        d = rand_stim(4'd10); d.alusrc = 1'b0; d.b = corner(3); d.ctrl[1] = 1'b1;
        @(negedge clk); apply(d);
        repeat (11) @(posedge clk);
        @(negedge clk); flush = 1'b1; #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL flush_bubble: got %h expected 0", obs); end
        s = rand_stim(4'd0);
        @(negedge clk); flush = 1'b0; apply(s); #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_add_busy: got %b", busy); end
        @(posedge clk); #1;
        checks++;
        if (obs !== expect_of(s)) begin
            failures++; $display("FAIL flush_add: got %h expected %h", obs, expect_of(s));
        end
        // Div held across a flush must restart from scratch.
        exp = expect_of(d);
        @(negedge clk); apply(d);
        repeat (5) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); flush = 1'b0;
        lat = 0;
        for (int e = 1; e <= 40 && lat == 0; e++) begin
            @(posedge clk); #1;
            if (out_RegWrite === 1'b1) lat = e;
        end
        checks++;
        if (lat !== 34) begin failures++; $display("FAIL flush_restart_lat: got %0d expected 34", lat); end
        checks++;
        if (obs !== exp) begin
            failures++; $display("FAIL flush_restart_val: got %h expected %h", obs, exp);
        end
        @(negedge clk); s = '0; apply(s);
    endtask

    task automatic test_reset_mid_div();
        stim_t s;
        int lat;
        s = rand_stim(4'd11); s.alusrc = 1'b0; s.b = corner(3); s.ctrl[1] = 1'b1;
        @(negedge clk); apply(s);
        repeat (8) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL rst_mid: got %h expected 0", obs); end
        @(posedge clk); #1;
        s = '0; s.op = 4'd11; s.a = 32'd100; s.b = 32'd7; s.ctrl = 5'b00010; s.rd = 5'd9;
        @(negedge clk); rst = 1'b0; apply(s);
        lat = 0;
        for (int e = 1; e <= 40 && lat == 0; e++) begin
            @(posedge clk); #1;
            if (out_RegWrite === 1'b1) lat = e;
        end
        checks++;
        if (lat !== 34) begin failures++; $display("FAIL rst_divu_lat: got %0d expected 34", lat); end
        checks++;
        if (out_AluResult !== 32'd14) begin
            failures++; $display("FAIL rst_divu_val: got %h expected 0000000e", out_AluResult);
        end
        @(negedge clk); s = '0; apply(s);
    endtask

    initial begin
        stim_t z;
        z = '0;
        rst = 1'b1;
        flush = 1'b0;
        apply(z);
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_div();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
